// File: rtl/tdes_key_sched_ctrl.sv
// Round key sequencer for Triple DES EDE: drives key/direction per pass and steps 16 round indices.
// Optional key parity checking is enabled with the TDES_KEY_PARITY_CHECK_EN macro.
module tdes_key_sched_ctrl #(
  parameter int unsigned NUM_PASSES   = 3,
  parameter int unsigned SETUP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        mode,
  input  logic [0:63] key_1,
  input  logic [0:63] key_2,
  input  logic [0:63] key_3,
  input  logic        round_ack,
  output logic [0:63] user_key,
  output logic        encr_decr,
  output logic [3:0]  round_idx,
  output logic [1:0]  pass_idx,
  output logic        round_valid,
  output logic        busy,
  output logic        done,
  output logic        key_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSetup = 2'd1;
  localparam logic [1:0] StRound = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [1:0] LastPass  = 2'(NUM_PASSES - 1);
  localparam logic [1:0] LastSetup = 2'(SETUP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  pass_q, pass_d;
  logic [3:0]  round_q, round_d;
  logic [1:0]  setup_cnt_q, setup_cnt_d;
  logic        mode_q, mode_d;
  logic [0:63] k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [0:63] user_key_q, user_key_d;
  logic        encr_decr_q, encr_decr_d;
  logic        par_fail;

  // EDE pass table; encrypt runs k1/E, k2/D, k3/E and decrypt mirrors it.
  function automatic logic [0:63] sel_key(input logic m, input logic [1:0] p,
                                          input logic [0:63] a, input logic [0:63] b,
                                          input logic [0:63] c);
    logic [0:63] k;
    if (NUM_PASSES == 1) begin
      k = a;
    end else begin
      case (p)
        2'd0:    k = m ? a : c;
        2'd1:    k = b;
        default: k = m ? c : a;
      endcase
    end
    return k;
  endfunction

  function automatic logic sel_dir(input logic m, input logic [1:0] p);
    logic d;
    if (NUM_PASSES == 1) begin
      d = m;
    end else begin
      d = (p == 2'd1) ? ~m : m;
    end
    return d;
  endfunction

`ifdef TDES_KEY_PARITY_CHECK_EN
  logic key_err_q, key_err_d;

  function automatic logic parity_ok(input logic [0:63] a, input logic [0:63] b,
                                     input logic [0:63] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ok = ok & (^a[8*i +: 8]) & (^b[8*i +: 8]) & (^c[8*i +: 8]);
    end
    return ok;
  endfunction

  assign par_fail = ~parity_ok(k1_q, k2_q, k3_q);
  assign key_err  = key_err_q;
`else
  assign par_fail = 1'b0;
  assign key_err  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    round_d     = round_q;
    setup_cnt_d = setup_cnt_q;
    mode_d      = mode_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    k3_d        = k3_q;
    user_key_d  = user_key_q;
    encr_decr_d = encr_decr_q;
`ifdef TDES_KEY_PARITY_CHECK_EN
    key_err_d   = key_err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          k1_d        = key_1;
          k2_d        = key_2;
          k3_d        = key_3;
          mode_d      = mode;
          pass_d      = 2'd0;
          round_d     = 4'd0;
          setup_cnt_d = 2'd0;
          user_key_d  = sel_key(mode, 2'd0, key_1, key_2, key_3);
          encr_decr_d = sel_dir(mode, 2'd0);
`ifdef TDES_KEY_PARITY_CHECK_EN
          key_err_d   = 1'b0;
`endif
          state_d     = StSetup;
        end
      end
      StSetup: begin
        // Parity is judged on the latched keys in the first setup cycle of pass 0.
        if (par_fail && pass_q == 2'd0 && setup_cnt_q == 2'd0) begin
          state_d   = StDone;
`ifdef TDES_KEY_PARITY_CHECK_EN
          key_err_d = 1'b1;
`endif
        end else if (setup_cnt_q == LastSetup) begin
          setup_cnt_d = 2'd0;
          state_d     = StRound;
        end else begin
          setup_cnt_d = setup_cnt_q + 2'd1;
        end
      end
      StRound: begin
        if (round_ack) begin
          if (round_q != 4'd15) begin
            round_d = round_q + 4'd1;
          end else begin
            round_d = 4'd0;
            if (pass_q != LastPass) begin
              pass_d      = pass_q + 2'd1;
              setup_cnt_d = 2'd0;
              user_key_d  = sel_key(mode_q, pass_q + 2'd1, k1_q, k2_q, k3_q);
              encr_decr_d = sel_dir(mode_q, pass_q + 2'd1);
              state_d     = StSetup;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      pass_q      <= 2'd0;
      round_q     <= 4'd0;
      setup_cnt_q <= 2'd0;
      mode_q      <= 1'b0;
      k1_q        <= '0;
      k2_q        <= '0;
      k3_q        <= '0;
      user_key_q  <= '0;
      encr_decr_q <= 1'b1;
`ifdef TDES_KEY_PARITY_CHECK_EN
      key_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      round_q     <= round_d;
      setup_cnt_q <= setup_cnt_d;
      mode_q      <= mode_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      k3_q        <= k3_d;
      user_key_q  <= user_key_d;
      encr_decr_q <= encr_decr_d;
`ifdef TDES_KEY_PARITY_CHECK_EN
      key_err_q   <= key_err_d;
`endif
    end
  end

  assign user_key    = user_key_q;
  assign encr_decr   = encr_decr_q;
  assign round_idx   = round_q;
  assign pass_idx    = pass_q;
  assign round_valid = (state_q == StRound);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

endmodule
